conv_seq_ctrl: RTL and testbench

//  Layer sequencer for the convolution datapath. On a conv_start request it precomputes per-phase beat counts.
//  It then steps the stream datapath through RX_FMAP -> RX_BIAS -> {RX_WGT -> COMPUTE -> TX_OUT} per output-channel tile.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_beat_counter.sv | 27 ++
 rtl/conv_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution layer sequencer.
// The state encoding doubles as the externally visible phase code.
package conv_pkg;

    localparam int BPB   = 4;
    localparam int CNT_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_RX_FMAP = 3'd2,
        ST_RX_BIAS = 3'd3,
        ST_RX_WGT  = 3'd4,
        ST_COMPUTE = 3'd5,
        ST_TX_OUT  = 3'd6,
        ST_DONE    = 3'd7
    } conv_state_t;

    // Element count to 32-bit beat count, rounding a partial beat up.
    function automatic logic [CNT_W-1:0] ceil_div4(input logic [CNT_W-1:0] elems);
        return (elems + CNT_W'(BPB - 1)) / CNT_W'(BPB);
    endfunction

endpackage

// File: rtl/conv_beat_counter.sv
// Beat counter shared by every streaming phase of the sequencer.
// is_last flags the beat that completes the current target.
module conv_beat_counter
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] cnt,
    output logic             is_last
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign is_last = (cnt == target - CNT_W'(1));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer: walks the conv datapath through fmap, bias and per-tile
// weight/compute/output phases, counting AXIS beats to decide phase ends.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int TILE_OC = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       conv_start,
    input  logic [9:0] cfg_in_ch,
    input  logic [9:0] cfg_out_ch,
    input  logic [5:0] cfg_fmap_w,
    input  logic       in_fire,
    input  logic       in_last,
    input  logic       out_fire,
    input  logic       compute_done,
    output logic [2:0] phase,
    output logic       s_ready_en,
    output logic       m_valid_en,
    output logic       m_last,
    output logic       compute_go,
    output logic [9:0] oc_base,
    output logic [6:0] oc_cnt,
    output logic       conv_done,
    output logic       err_tlast,
    output logic       err_cfg
);

    conv_state_t      state;
    logic             start_q;
    logic [9:0]       in_ch_q;
    logic [9:0]       out_ch_q;
    logic [11:0]      ww_q;
    logic [CNT_W-1:0] fmap_beats;
    logic [CNT_W-1:0] bias_beats;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt;
    logic             is_last;

    function automatic logic [6:0] min_tile(input logic [10:0] remaining);
        return (remaining < 11'(TILE_OC)) ? remaining[6:0] : 7'(TILE_OC);
    endfunction

    // in_fire/out_fire are completed handshakes (TVALID & TREADY) seen by the
    // datapath; this block only grants permission via s_ready_en/m_valid_en.
    logic        rx_phase;
    logic        counting;
    logic        beat_en;
    logic        phase_end;
    logic        start_edge;
    logic [11:0] ww_calc;
    logic [10:0] tile_end;
    logic        last_tile;

    assign rx_phase   = (state == ST_RX_FMAP) || (state == ST_RX_BIAS) || (state == ST_RX_WGT);
    assign counting   = rx_phase || (state == ST_TX_OUT);
    assign beat_en    = (rx_phase && in_fire) || ((state == ST_TX_OUT) && out_fire);
    assign phase_end  = beat_en && is_last;
    assign start_edge = conv_start && !start_q;
    assign ww_calc    = 12'(cfg_fmap_w) * 12'(cfg_fmap_w);
    assign tile_end   = 11'(oc_base) + 11'(oc_cnt);
    assign last_tile  = (tile_end >= {1'b0, out_ch_q});

    assign phase      = state;
    assign s_ready_en = rx_phase;
    assign m_valid_en = (state == ST_TX_OUT);
    assign m_last     = (state == ST_TX_OUT) && last_tile && is_last;

    always_comb begin
        target = CNT_W'(1);
        case (state)
            ST_RX_FMAP: target = fmap_beats;
            ST_RX_BIAS: target = bias_beats;
            ST_RX_WGT:  target = ceil_div4(CNT_W'(oc_cnt) * CNT_W'(in_ch_q) * CNT_W'(9));
            ST_TX_OUT:  target = ceil_div4(CNT_W'(oc_cnt) * CNT_W'(ww_q));
            default:    target = CNT_W'(1);
        endcase
    end

    conv_beat_counter u_beat_counter (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (!counting || phase_end),
        .en      (beat_en),
        .target  (target),
        .cnt     (cnt),
        .is_last (is_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            start_q    <= 1'b1;
            in_ch_q    <= '0;
            out_ch_q   <= '0;
            ww_q       <= '0;
            fmap_beats <= '0;
            bias_beats <= '0;
            oc_base    <= '0;
            oc_cnt     <= '0;
            compute_go <= 1'b0;
            conv_done  <= 1'b0;
            err_tlast  <= 1'b0;
            err_cfg    <= 1'b0;
        end else begin
            start_q    <= conv_start;
            compute_go <= 1'b0;
            if ((in_fire && !rx_phase) || (out_fire && state != ST_TX_OUT)) begin
                err_tlast <= 1'b1;
            end
            if (rx_phase && in_fire && (in_last != is_last)) begin
                err_tlast <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state     <= ST_CALC;
                        err_tlast <= 1'b0;
                        err_cfg   <= 1'b0;
                    end
                end
                ST_CALC: begin
                    in_ch_q    <= cfg_in_ch;
                    out_ch_q   <= cfg_out_ch;
                    ww_q       <= ww_calc;
                    fmap_beats <= ceil_div4(CNT_W'(cfg_in_ch) * CNT_W'(ww_calc));
                    bias_beats <= ceil_div4(CNT_W'(cfg_out_ch));
                    oc_base    <= '0;
                    oc_cnt     <= min_tile({1'b0, cfg_out_ch});
                    if (cfg_in_ch == '0 || cfg_out_ch == '0 || cfg_fmap_w == '0) begin
                        err_cfg   <= 1'b1;
                        conv_done <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_RX_FMAP;
                    end
                end
                ST_RX_FMAP: if (phase_end) state <= ST_RX_BIAS;
                ST_RX_BIAS: if (phase_end) state <= ST_RX_WGT;
                ST_RX_WGT: begin
                    if (phase_end) begin
                        state      <= ST_COMPUTE;
                        compute_go <= 1'b1;
                    end
                end
                ST_COMPUTE: if (compute_done) state <= ST_TX_OUT;
                ST_TX_OUT: begin
                    if (phase_end) begin
                        if (!last_tile) begin
                            oc_base <= tile_end[9:0];
                            oc_cnt  <= min_tile({1'b0, out_ch_q} - tile_end);
                            state   <= ST_RX_WGT;
                        end else begin
                            conv_done <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!conv_start) begin
                        conv_done <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: table of layer configs with hand-computed
// beat counts, plus hand-written reset, stray-fire and bad-config sequences.
module tb_conv_seq_ctrl;
    import conv_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       conv_start;
    logic [9:0] cfg_in_ch;
    logic [9:0] cfg_out_ch;
    logic [5:0] cfg_fmap_w;
    logic       in_fire;
    logic       in_last;
    logic       out_fire;
    logic       compute_done;
    logic [2:0] phase;
    logic       s_ready_en;
    logic       m_valid_en;
    logic       m_last;
    logic       compute_go;
    logic [9:0] oc_base;
    logic [6:0] oc_cnt;
    logic       conv_done;
    logic       err_tlast;
    logic       err_cfg;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.TILE_OC(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .conv_start   (conv_start),
        .cfg_in_ch    (cfg_in_ch),
        .cfg_out_ch   (cfg_out_ch),
        .cfg_fmap_w   (cfg_fmap_w),
        .in_fire      (in_fire),
        .in_last      (in_last),
        .out_fire     (out_fire),
        .compute_done (compute_done),
        .phase        (phase),
        .s_ready_en   (s_ready_en),
        .m_valid_en   (m_valid_en),
        .m_last       (m_last),
        .compute_go   (compute_go),
        .oc_base      (oc_base),
        .oc_cnt       (oc_cnt),
        .conv_done    (conv_done),
        .err_tlast    (err_tlast),
        .err_cfg      (err_cfg)
    );

    typedef struct {
        int in_ch;
        int out_ch;
        int w;
        int bad_beat;
        int fmap;
        int bias;
        int wgt0;
        int out0;
        int wgt1;
        int out1;
        int tiles;
        int last_base;
        int last_cnt;
        int err_t;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in_fire      = 1'b0;
        in_last      = 1'b0;
        out_fire     = 1'b0;
        compute_done = 1'b0;
    endtask

    task automatic run_layer(input vec_t v, input string tag);
        int fmap_n = 0, bias_n = 0, go_n = 0, mlast_n = 0, mlast_ok = 0;
        int wgt_n[2] = '{0, 0};
        int out_n[2] = '{0, 0};
        int t = 0, cur = 0, lat = -1, timer = 0, tgt = 0;
        int seen_base = -1, seen_cnt = -1;
        bit finished = 0;
        logic [2:0] ph, prev;
        cfg_in_ch  = 10'(v.in_ch);
        cfg_out_ch = 10'(v.out_ch);
        cfg_fmap_w = 6'(v.w);
        conv_start = 1'b0;
        clear_inputs();
        @(negedge clk);
        conv_start = 1'b1;
        prev = phase;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            ph = phase;
            if (ph != prev) begin
                cur = 0;
                if (ph == ST_RX_WGT && prev == ST_TX_OUT) t++;
                prev = ph;
            end
            if (lat < 0 && s_ready_en) lat = cyc + 1;
            if (ph == ST_RX_WGT) begin
                seen_base = int'(oc_base);
                seen_cnt  = int'(oc_cnt);
            end
            if (compute_go) begin
                go_n++;
                timer = 3;
            end
            compute_done = (timer == 1);
            if (timer > 0) timer--;
            in_fire  = 1'b0;
            in_last  = 1'b0;
            out_fire = 1'b0;
            if (conv_done) begin
                finished = 1;
            end else if (s_ready_en && $urandom_range(0, 3) != 0) begin
                if (ph == ST_RX_FMAP) tgt = v.fmap;
                else if (ph == ST_RX_BIAS) tgt = v.bias;
                else tgt = (t == 0) ? v.wgt0 : v.wgt1;
                in_fire = 1'b1;
                in_last = (cur == tgt - 1) || (ph == ST_RX_FMAP && cur + 1 == v.bad_beat);
                if (ph == ST_RX_FMAP) fmap_n++;
                else if (ph == ST_RX_BIAS) bias_n++;
                else if (t < 2) wgt_n[t]++;
                cur++;
            end else if (m_valid_en && $urandom_range(0, 3) != 0) begin
                tgt = (t == 0) ? v.out0 : v.out1;
                out_fire = 1'b1;
                if (m_last) begin
                    mlast_n++;
                    if (t == v.tiles - 1 && cur == tgt - 1) mlast_ok++;
                end
                if (t < 2) out_n[t]++;
                cur++;
            end
        end
        clear_inputs();
        if (!finished) $display("FAIL %s timeout waiting for conv_done", tag);
        check({tag, " finished"}, int'(finished), 1);
        check({tag, " start_latency"}, lat, 2);
        check({tag, " fmap_beats"}, fmap_n, v.fmap);
        check({tag, " bias_beats"}, bias_n, v.bias);
        check({tag, " wgt_beats_t0"}, wgt_n[0], v.wgt0);
        check({tag, " out_beats_t0"}, out_n[0], v.out0);
        check({tag, " wgt_beats_t1"}, wgt_n[1], v.wgt1);
        check({tag, " out_beats_t1"}, out_n[1], v.out1);
        check({tag, " tiles"}, t + 1, v.tiles);
        check({tag, " go_pulses"}, go_n, v.tiles);
        check({tag, " m_last_count"}, mlast_n, 1);
        check({tag, " m_last_position"}, mlast_ok, 1);
        check({tag, " last_oc_base"}, seen_base, v.last_base);
        check({tag, " last_oc_cnt"}, seen_cnt, v.last_cnt);
        check({tag, " conv_done"}, int'(conv_done), 1);
        check({tag, " phase_done"}, int'(phase), int'(ST_DONE));
        check({tag, " err_tlast"}, int'(err_tlast), v.err_t);
        check({tag, " err_cfg"}, int'(err_cfg), 0);
        conv_start = 1'b0;
        @(negedge clk);
        check({tag, " done_cleared"}, int'(conv_done), 0);
        check({tag, " back_to_idle"}, int'(phase), int'(ST_IDLE));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " phase"}, int'(phase), 0);
        check({tag, " s_ready_en"}, int'(s_ready_en), 0);
        check({tag, " m_valid_en"}, int'(m_valid_en), 0);
        check({tag, " m_last"}, int'(m_last), 0);
        check({tag, " compute_go"}, int'(compute_go), 0);
        check({tag, " oc_base"}, int'(oc_base), 0);
        check({tag, " oc_cnt"}, int'(oc_cnt), 0);
        check({tag, " conv_done"}, int'(conv_done), 0);
        check({tag, " err_tlast"}, int'(err_tlast), 0);
        check({tag, " err_cfg"}, int'(err_cfg), 0);
    endtask

    initial begin
        int en_seen;
        //           in out w  bad fm bi w0  o0  w1  o1 tl base cnt err
        vecs[0] = '{4, 8,  4, 0,  16, 2, 72, 32, 0,  0,  1, 0, 8, 0};
        vecs[1] = '{4, 12, 4, 0,  16, 3, 72, 32, 36, 16, 2, 8, 4, 0};
        vecs[2] = '{3, 1,  3, 0,  7,  1, 7,  3,  0,  0,  1, 0, 1, 0};
        vecs[3] = '{4, 8,  4, 10, 16, 2, 72, 32, 0,  0,  1, 0, 8, 1};
        vecs[4] = '{1, 9,  1, 0,  1,  3, 18, 2,  3,  1,  2, 8, 1, 0};

        rstn       = 1'b0;
        conv_start = 1'b0;
        cfg_in_ch  = '0;
        cfg_out_ch = '0;
        cfg_fmap_w = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Stray output handshake while idle is flagged, then cleared by the next start.
        out_fire = 1'b1;
        @(negedge clk);
        out_fire = 1'b0;
        @(negedge clk);
        check("stray_out_fire err_tlast", int'(err_tlast), 1);
        check("stray_out_fire phase", int'(phase), int'(ST_IDLE));

        for (int i = 0; i < 5; i++) begin
            run_layer(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero input-channel config: error and done two cycles after the edge.
        cfg_in_ch  = 10'd0;
        cfg_out_ch = 10'd8;
        cfg_fmap_w = 6'd4;
        en_seen    = 0;
        @(negedge clk);
        conv_start = 1'b1;
        @(negedge clk);
        check("cfg0 phase_calc", int'(phase), int'(ST_CALC));
        check("cfg0 done_early", int'(conv_done), 0);
        @(negedge clk);
        check("cfg0 conv_done", int'(conv_done), 1);
        check("cfg0 err_cfg", int'(err_cfg), 1);
        for (int k = 0; k < 4; k++) begin
            if (s_ready_en || m_valid_en) en_seen++;
            @(negedge clk);
        end
        check("cfg0 enables_seen", en_seen, 0);
        conv_start = 1'b0;
        @(negedge clk);
        check("cfg0 idle", int'(phase), int'(ST_IDLE));
        check("cfg0 err_cfg_sticky", int'(err_cfg), 1);

        // Reset in the middle of weight reception.
        cfg_in_ch  = 10'd4;
        cfg_out_ch = 10'd8;
        cfg_fmap_w = 6'd4;
        conv_start = 1'b1;
        en_seen    = 0;
        for (int k = 0; k < 400 && en_seen < 5; k++) begin
            @(negedge clk);
            if (phase == ST_RX_WGT) en_seen++;
            in_fire = s_ready_en;
        end
        check("midwgt reached", en_seen, 5);
        in_fire = 1'b0;
        rstn    = 1'b0;
        #1;
        check_all_zero("midwgt_reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("start_high_at_release idle", int'(phase), int'(ST_IDLE));
        check("start_high_at_release ready", int'(s_ready_en), 0);
        run_layer(vecs[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
